// File: rtl/pipe_skid_reg.sv
// Purpose: inter-stage pipeline register with valid/ready handshake, optional 2-entry skid, flush and stall counter.
// Latency: 1 cycle from in_fire to out_*; payloads leave in arrival order.
// Backpressure: out_ready low holds the payload; SKID_EN=1 drops in_ready one cycle after filling, SKID_EN=0 drops it combinationally.
module pipe_skid_reg #(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013,
  parameter bit                   SKID_EN   = 1'b1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4,
  output logic [1:0]         occ,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc4_q, main_pc4_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // Skid mode uses a registered ready so out_ready never reaches in_ready combinationally;
  // the single-entry variant can accept whenever the held entry leaves this cycle.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_instr = main_instr_q;
  assign out_pc4   = main_pc4_q;
  assign occ       = state_q;
  assign stall_cnt = stall_cnt_q;

  // Next state and payload movement; flush overrides every other transition and drops any in_fire.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc4_d   = main_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    if (flush) begin
      state_d      = ST_EMPTY;
      main_instr_d = NOP_INSTR;
      main_pc4_d   = '0;
      skid_instr_d = NOP_INSTR;
      skid_pc4_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            main_instr_d = in_instr;
            main_pc4_d   = in_pc4;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_instr_d = in_instr;
            main_pc4_d   = in_pc4;
          end else if (in_fire) begin
            // Only reachable with the skid enabled: without it in_fire implies out_fire here.
            state_d      = ST_FULL;
            skid_instr_d = in_instr;
            skid_pc4_d   = in_pc4;
          end else if (out_fire) begin
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc4_d   = '0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d      = ST_ONE;
            main_instr_d = skid_instr_q;
            main_pc4_d   = skid_pc4_q;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_instr_d = NOP_INSTR;
          main_pc4_d   = '0;
        end
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  // Saturating count of cycles where downstream refuses a presented payload.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, payload and counter registers; reset empties the stage immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc4_q   <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc4_q   <= main_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule
